mem_port_arbiter: RTL and testbench

//   Shares the single-port memory between two requesters: instruction fetch (IF) and LD/ST data access (D).

---
 rtl/mem_port_arbiter_if.sv | 58 +++++
 rtl/mem_port_arbiter.sv | 258 +++++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter_if
//   Groups the signals of the two-requester memory port arbiter: the
//   instruction-fetch (IF) read port, the data (D) load/store port, the
//   memory macro port and the busy flag.
//
//   Modports
//     slave  : the arbiter (takes requests and mem_rdata, drives grants,
//              responses and the memory strobe)
//     master : the environment (requesters plus memory macro)
//
//   Signals
//     if_req/if_addr              IF read request, held until if_gnt
//     if_gnt/if_rvalid/if_rdata   IF grant pulse, response pulse, read data
//     d_req/d_we/d_addr/d_wdata   D request, held until d_gnt
//     d_gnt/d_rvalid/d_rdata      D grant pulse, response pulse, load data
//     mem_en/mem_we/mem_addr/mem_wdata  memory access strobe and payload
//     mem_rdata                   memory read data, MEM_LAT cycles after mem_en
//     busy                        arbiter is not idle
// ----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32'sd8,
   parameter int DATA_W = 32'sd8
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_gnt;
   logic              d_rvalid;
   logic [DATA_W-1:0] d_rdata;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic              busy;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
             mem_en, mem_we, mem_addr, mem_wdata, busy
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
             mem_en, mem_we, mem_addr, mem_wdata, busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares a single-port memory between instruction fetch (IF) and LD/ST
//   data access (D). One transaction is outstanding at a time. D has
//   priority, but IF is forced to win after MAX_WAIT consecutive losses.
//   The read response is captured and returned to the owning requester.
//
//   Parameters
//     ADDR_W    memory address width
//     DATA_W    memory data width
//     MEM_LAT   cycles from mem_en to valid mem_rdata (>=1)
//     MAX_WAIT  IF losses tolerated before IF is forced to win (>=1)
//
//   Ports
//     clk    rising-edge clock
//     reset  asynchronous, active-high
//     bus    mem_port_arbiter_if.slave (requests, responses, memory port)
//
//   Sequence: IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> RESP -> ISSUE|IDLE.
//   IDLE and RESP are the arbitration points. All outputs are registered:
//   they are computed from the next state and the next latched
//   transaction, so they appear in the same cycle as that state.
// ----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int ADDR_W   = 32'sd8,
   parameter int DATA_W   = 32'sd8,
   parameter int MEM_LAT  = 32'sd1,
   parameter int MAX_WAIT = 32'sd2
) (
   input logic               clk,
   input logic               reset,
   mem_port_arbiter_if.slave bus
);

   localparam int LAT_W  = (MEM_LAT > 32'sd1) ? $clog2(MEM_LAT) : 32'sd1;
   localparam int STRV_W = $clog2(MAX_WAIT + 32'sd1);

   localparam logic [LAT_W-1:0]  LAT_INIT  = LAT_W'(MEM_LAT - 32'sd1);
   localparam logic [LAT_W-1:0]  LAT_ZERO  = {LAT_W{1'b0}};
   localparam logic [LAT_W-1:0]  LAT_ONE   = LAT_W'(1'b1);
   localparam logic [STRV_W-1:0] STRV_MAX  = STRV_W'(MAX_WAIT);
   localparam logic [STRV_W-1:0] STRV_ZERO = {STRV_W{1'b0}};
   localparam logic [STRV_W-1:0] STRV_ONE  = STRV_W'(1'b1);
   localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
   localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_D  = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t            state_r;
   state_t            state_nxt_s;

   logic [LAT_W-1:0]  lat_cnt_r;
   logic [LAT_W-1:0]  lat_cnt_nxt_s;
   logic [STRV_W-1:0] starve_cnt_r;
   logic [STRV_W-1:0] starve_cnt_nxt_s;

   // latched transaction
   logic              owner_r;
   logic              owner_nxt_s;
   logic              we_r;
   logic              we_nxt_s;
   logic [ADDR_W-1:0] addr_r;
   logic [ADDR_W-1:0] addr_nxt_s;
   logic [DATA_W-1:0] wdata_r;
   logic [DATA_W-1:0] wdata_nxt_s;

   logic              arb_pt_s;
   logic              any_req_s;
   logic              both_req_s;
   logic              if_wins_s;
   logic              d_wins_s;
   logic              resp_cap_s;
   logic              issue_s;

   // registered outputs and their next values
   logic              if_gnt_r,    if_gnt_nxt_s;
   logic              if_rvalid_r, if_rvalid_nxt_s;
   logic [DATA_W-1:0] if_rdata_r,  if_rdata_nxt_s;
   logic              d_gnt_r,     d_gnt_nxt_s;
   logic              d_rvalid_r,  d_rvalid_nxt_s;
   logic [DATA_W-1:0] d_rdata_r,   d_rdata_nxt_s;
   logic              mem_en_r,    mem_en_nxt_s;
   logic              mem_we_r,    mem_we_nxt_s;
   logic [ADDR_W-1:0] mem_addr_r,  mem_addr_nxt_s;
   logic [DATA_W-1:0] mem_wdata_r, mem_wdata_nxt_s;
   logic              busy_r,      busy_nxt_s;

   // arbitration decision, only meaningful in IDLE and RESP
   always_comb begin
      arb_pt_s   = (state_r == IDLE) || (state_r == RESP);
      any_req_s  = bus.if_req || bus.d_req;
      both_req_s = bus.if_req && bus.d_req;
      // IF wins when alone, or when it has already lost MAX_WAIT times in a row
      if_wins_s  = arb_pt_s && bus.if_req && (!bus.d_req || (starve_cnt_r == STRV_MAX));
      d_wins_s   = arb_pt_s && bus.d_req && !if_wins_s;
      resp_cap_s = (state_r == WAIT) && (lat_cnt_r == LAT_ZERO);
   end

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE:    state_nxt_s = any_req_s ? ISSUE : IDLE;
         ISSUE:   state_nxt_s = WAIT;
         WAIT:    state_nxt_s = (lat_cnt_r == LAT_ZERO) ? RESP : WAIT;
         RESP:    state_nxt_s = any_req_s ? ISSUE : IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // next values of the latched transaction and the two counters
   always_comb begin
      owner_nxt_s      = owner_r;
      we_nxt_s         = we_r;
      addr_nxt_s       = addr_r;
      wdata_nxt_s      = wdata_r;
      starve_cnt_nxt_s = starve_cnt_r;
      lat_cnt_nxt_s    = lat_cnt_r;

      if (if_wins_s) begin
         owner_nxt_s = OWN_IF;
         we_nxt_s    = 1'b0;
         addr_nxt_s  = bus.if_addr;
         wdata_nxt_s = DATA_ZERO;
      end else if (d_wins_s) begin
         owner_nxt_s = OWN_D;
         we_nxt_s    = bus.d_we;
         addr_nxt_s  = bus.d_addr;
         wdata_nxt_s = bus.d_wdata;
      end else begin
         owner_nxt_s = owner_r;
      end

      // losses only count when IF actually competed against D
      if (if_wins_s) begin
         starve_cnt_nxt_s = STRV_ZERO;
      end else if (d_wins_s && both_req_s && (starve_cnt_r != STRV_MAX)) begin
         starve_cnt_nxt_s = starve_cnt_r + STRV_ONE;
      end else begin
         starve_cnt_nxt_s = starve_cnt_r;
      end

      if (state_r == ISSUE) begin
         lat_cnt_nxt_s = LAT_INIT;
      end else if ((state_r == WAIT) && (lat_cnt_r != LAT_ZERO)) begin
         lat_cnt_nxt_s = lat_cnt_r - LAT_ONE;
      end else begin
         lat_cnt_nxt_s = lat_cnt_r;
      end
   end

   // transaction latches and counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         owner_r      <= OWN_IF;
         we_r         <= 1'b0;
         addr_r       <= ADDR_ZERO;
         wdata_r      <= DATA_ZERO;
         starve_cnt_r <= STRV_ZERO;
         lat_cnt_r    <= LAT_ZERO;
      end else begin
         owner_r      <= owner_nxt_s;
         we_r         <= we_nxt_s;
         addr_r       <= addr_nxt_s;
         wdata_r      <= wdata_nxt_s;
         starve_cnt_r <= starve_cnt_nxt_s;
         lat_cnt_r    <= lat_cnt_nxt_s;
      end
   end

   // output logic: next values of the registered outputs
   always_comb begin
      issue_s         = (state_nxt_s == ISSUE);
      mem_en_nxt_s    = issue_s;
      mem_we_nxt_s    = issue_s && we_nxt_s;
      mem_addr_nxt_s  = issue_s ? addr_nxt_s  : ADDR_ZERO;
      mem_wdata_nxt_s = issue_s ? wdata_nxt_s : DATA_ZERO;
      if_gnt_nxt_s    = issue_s && (owner_nxt_s == OWN_IF);
      d_gnt_nxt_s     = issue_s && (owner_nxt_s == OWN_D);
      busy_nxt_s      = (state_nxt_s != IDLE);

      // the last WAIT cycle samples mem_rdata straight into the response register
      if_rvalid_nxt_s = resp_cap_s && (owner_r == OWN_IF);
      d_rvalid_nxt_s  = resp_cap_s && (owner_r == OWN_D);

      if (if_rvalid_nxt_s) begin
         if_rdata_nxt_s = bus.mem_rdata;
      end else begin
         if_rdata_nxt_s = if_rdata_r;
      end

      // a completed store reports zero data
      if (d_rvalid_nxt_s) begin
         d_rdata_nxt_s = we_r ? DATA_ZERO : bus.mem_rdata;
      end else begin
         d_rdata_nxt_s = d_rdata_r;
      end
   end

   // output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         if_gnt_r    <= 1'b0;
         if_rvalid_r <= 1'b0;
         if_rdata_r  <= DATA_ZERO;
         d_gnt_r     <= 1'b0;
         d_rvalid_r  <= 1'b0;
         d_rdata_r   <= DATA_ZERO;
         mem_en_r    <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= ADDR_ZERO;
         mem_wdata_r <= DATA_ZERO;
         busy_r      <= 1'b0;
      end else begin
         if_gnt_r    <= if_gnt_nxt_s;
         if_rvalid_r <= if_rvalid_nxt_s;
         if_rdata_r  <= if_rdata_nxt_s;
         d_gnt_r     <= d_gnt_nxt_s;
         d_rvalid_r  <= d_rvalid_nxt_s;
         d_rdata_r   <= d_rdata_nxt_s;
         mem_en_r    <= mem_en_nxt_s;
         mem_we_r    <= mem_we_nxt_s;
         mem_addr_r  <= mem_addr_nxt_s;
         mem_wdata_r <= mem_wdata_nxt_s;
         busy_r      <= busy_nxt_s;
      end
   end

   assign bus.if_gnt    = if_gnt_r;
   assign bus.if_rvalid = if_rvalid_r;
   assign bus.if_rdata  = if_rdata_r;
   assign bus.d_gnt     = d_gnt_r;
   assign bus.d_rvalid  = d_rvalid_r;
   assign bus.d_rdata   = d_rdata_r;
   assign bus.mem_en    = mem_en_r;
   assign bus.mem_we    = mem_we_r;
   assign bus.mem_addr  = mem_addr_r;
   assign bus.mem_wdata = mem_wdata_r;
   assign bus.busy      = busy_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Self-checking bench for mem_port_arbiter. dut1 runs with MEM_LAT=1 and
//   dut3 with MEM_LAT=3 (both MAX_WAIT=2). Expected read data is pushed to
//   per-port queues when a request is driven or accepted, and popped and
//   compared when the DUT raises rvalid. Inputs are driven and outputs are
//   sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(8)) b1 ();
   mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(8)) b3 ();

   mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(1), .MAX_WAIT(2)) dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (b1.slave)
   );

   mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(3), .MAX_WAIT(2)) dut3 (
      .clk   (clk),
      .reset (reset),
      .bus   (b3.slave)
   );

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] if_q [$];
   logic [7:0] d_q  [$];

   // power-on memory image; 0x10 holds 0xAB
   function automatic logic [7:0] mem_init(input logic [7:0] a);
      return a ^ 8'hBB;
   endfunction

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // memory model for dut1: one-cycle read latency, 0xEE when nothing was read
   logic [7:0] mem1 [256];
   logic [7:0] rd1;
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 256; i++) mem1[i] <= mem_init(8'(i));
         rd1 <= 8'hEE;
      end else begin
         if (b1.mem_en && b1.mem_we) mem1[b1.mem_addr] <= b1.mem_wdata;
         rd1 <= b1.mem_en ? mem1[b1.mem_addr] : 8'hEE;
      end
   end
   assign b1.mem_rdata = rd1;

   // memory model for dut3: read-only image, three-cycle read pipe
   logic [7:0] rd3 [3];
   always @(posedge clk) begin
      if (reset) begin
         rd3[0] <= 8'hEE;
         rd3[1] <= 8'hEE;
         rd3[2] <= 8'hEE;
      end else begin
         rd3[0] <= b3.mem_en ? mem_init(b3.mem_addr) : 8'hEE;
         rd3[1] <= rd3[0];
         rd3[2] <= rd3[1];
      end
   end
   assign b3.mem_rdata = rd3[2];

   // response scoreboard and exclusivity checks for dut1
   always @(negedge clk) begin
      if (b1.if_rvalid) begin
         chk_eq("if_rv_pending", 32'(if_q.size() != 0), 32'd1);
         if (if_q.size() != 0) chk_eq("if_rdata", b1.if_rdata, if_q.pop_front());
      end
      if (b1.d_rvalid) begin
         chk_eq("d_rv_pending", 32'(d_q.size() != 0), 32'd1);
         if (d_q.size() != 0) chk_eq("d_rdata", b1.d_rdata, d_q.pop_front());
      end
      if (b1.if_gnt || b1.d_gnt) chk_eq("gnt_excl", b1.if_gnt & b1.d_gnt, 32'd0);
      if (b1.if_rvalid || b1.d_rvalid) chk_eq("rvalid_excl", b1.if_rvalid & b1.d_rvalid, 32'd0);
   end

   task automatic chk_all_zero(input string tag);
      chk_eq({tag, "_ctl"}, {b1.if_gnt, b1.if_rvalid, b1.d_gnt, b1.d_rvalid,
                             b1.mem_en, b1.mem_we, b1.busy}, 32'd0);
      chk_eq({tag, "_data"}, {b1.if_rdata, b1.d_rdata, b1.mem_addr, b1.mem_wdata}, 32'd0);
   endtask

   // single IF read on dut1 with latency checks
   task automatic t_if_read(input string tag, input logic [7:0] a, input logic [7:0] exp);
      b1.if_req  = 1'b1;
      b1.if_addr = a;
      if_q.push_back(exp);
      step();
      chk_eq({tag, "_gnt"}, {b1.if_gnt, b1.d_gnt, b1.mem_en, b1.mem_we, b1.busy}, 32'b10101);
      chk_eq({tag, "_maddr"}, b1.mem_addr, a);
      b1.if_req = 1'b0;
      step();
      chk_eq({tag, "_wait"}, {b1.if_rvalid, b1.mem_en, b1.if_gnt}, 32'd0);
      step();
      chk_eq({tag, "_rvalid"}, {b1.if_rvalid, b1.d_rvalid}, 32'b10);
      step();
      chk_eq({tag, "_idle"}, {b1.busy, b1.if_rvalid}, 32'd0);
   endtask

   // single D access on dut1 with latency checks
   task automatic t_d_access(input string tag, input logic we, input logic [7:0] a,
                             input logic [7:0] wd, input logic [7:0] exp);
      b1.d_req   = 1'b1;
      b1.d_we    = we;
      b1.d_addr  = a;
      b1.d_wdata = wd;
      d_q.push_back(exp);
      step();
      chk_eq({tag, "_gnt"}, {b1.d_gnt, b1.if_gnt, b1.mem_en, b1.mem_we}, {30'd0, 1'b1, 1'b0, 1'b1, we});
      chk_eq({tag, "_mbus"}, {b1.mem_addr, b1.mem_wdata}, {16'd0, a, wd});
      b1.d_req = 1'b0;
      step();
      chk_eq({tag, "_wait"}, {b1.d_rvalid, b1.mem_en}, 32'd0);
      step();
      chk_eq({tag, "_rvalid"}, {b1.d_rvalid, b1.if_rvalid}, 32'b10);
      step();
      chk_eq({tag, "_idle"}, b1.busy, 32'd0);
   endtask

   logic exp_order [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

   initial begin
      int ngnt;
      int cyc;
      int last;

      b1.if_req = 1'b0; b1.if_addr = 8'h00;
      b1.d_req = 1'b0; b1.d_we = 1'b0; b1.d_addr = 8'h00; b1.d_wdata = 8'h00;
      b3.if_req = 1'b0; b3.if_addr = 8'h00;
      b3.d_req = 1'b0; b3.d_we = 1'b0; b3.d_addr = 8'h00; b3.d_wdata = 8'h00;

      // reset state
      step();
      step();
      chk_all_zero("rst");
      chk_eq("rst3", {b3.if_gnt, b3.d_gnt, b3.mem_en, b3.busy, b3.if_rdata}, 32'd0);
      reset = 1'b0;
      step();

      // 1: IF read, MEM_LAT=1
      t_if_read("t1", 8'h10, 8'hAB);

      // 2: store, then read it back, then a store zeroes d_rdata
      t_d_access("t2st", 1'b1, 8'h20, 8'h55, 8'h00);
      chk_eq("t2_if_hold", b1.if_rdata, 32'hAB);
      t_d_access("t2ld", 1'b0, 8'h20, 8'h00, 8'h55);
      step();
      chk_eq("t2_d_hold", b1.d_rdata, 32'h55);
      t_d_access("t2st2", 1'b1, 8'h21, 8'h99, 8'h00);
      chk_eq("t2_d_zero", b1.d_rdata, 32'h00);

      // 4: IF read on the MEM_LAT=3 instance
      b3.if_req  = 1'b1;
      b3.if_addr = 8'h10;
      step();
      chk_eq("t4_gnt", {b3.if_gnt, b3.mem_en, b3.busy}, 32'b111);
      b3.if_req = 1'b0;
      for (int k = 2; k <= 5; k++) begin
         step();
         chk_eq("t4_mem_en", b3.mem_en, 32'd0);
         chk_eq("t4_rvalid", b3.if_rvalid, 32'(k == 5));
      end
      chk_eq("t4_rdata", b3.if_rdata, 32'hAB);
      step();
      chk_eq("t4_idle", b3.busy, 32'd0);

      // 3: both requesters continuously high
      b1.if_req  = 1'b1; b1.if_addr = 8'h30;
      b1.d_req   = 1'b1; b1.d_we = 1'b0; b1.d_addr = 8'h40; b1.d_wdata = 8'h00;
      ngnt = 0;
      cyc  = 0;
      last = 0;
      while ((ngnt < 6) && (cyc < 40)) begin
         step();
         cyc++;
         if (b1.if_gnt || b1.d_gnt) begin
            chk_eq("t3_order", b1.d_gnt, exp_order[ngnt]);
            if (ngnt > 0) chk_eq("t3_spacing", cyc - last, 32'd3);
            last = cyc;
            if (b1.d_gnt) d_q.push_back(mem_init(8'h40));
            else          if_q.push_back(mem_init(8'h30));
            ngnt++;
         end
      end
      chk_eq("t3_grants", ngnt, 32'd6);
      b1.if_req = 1'b0;
      b1.d_req  = 1'b0;
      repeat (4) step();
      chk_eq("t3_idle", b1.busy, 32'd0);

      // 6: IF drops req after gnt, D rises; D issued from RESP
      b1.if_req  = 1'b1;
      b1.if_addr = 8'h50;
      if_q.push_back(mem_init(8'h50));
      step();
      chk_eq("t6_if_gnt", b1.if_gnt, 32'd1);
      b1.if_req = 1'b0;
      b1.d_req  = 1'b1; b1.d_we = 1'b0; b1.d_addr = 8'h40;
      d_q.push_back(mem_init(8'h40));
      step();
      chk_eq("t6_no_early", b1.d_gnt, 32'd0);
      step();
      chk_eq("t6_if_rv", {b1.if_rvalid, b1.busy, b1.d_gnt}, 32'b110);
      step();
      chk_eq("t6_d_gnt", {b1.d_gnt, b1.busy}, 32'b11);
      chk_eq("t6_maddr", b1.mem_addr, 32'h40);
      b1.d_req = 1'b0;
      step();
      step();
      chk_eq("t6_d_rv", b1.d_rvalid, 32'd1);
      step();
      chk_eq("t6_idle", b1.busy, 32'd0);

      // 5: reset in WAIT of a D load drops the transaction
      b1.d_req = 1'b1; b1.d_we = 1'b0; b1.d_addr = 8'h40;
      step();
      chk_eq("t5_gnt", b1.d_gnt, 32'd1);
      b1.d_req = 1'b0;
      reset = 1'b1;
      step();
      chk_all_zero("t5_rst");
      reset = 1'b0;
      repeat (4) begin
         step();
         chk_eq("t5_quiet", {b1.d_rvalid, b1.busy}, 32'd0);
      end
      t_if_read("t5if", 8'h10, 8'hAB);

      // every expected response was consumed
      repeat (3) step();
      chk_eq("drain", if_q.size() + d_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
